barrel_shift_pipe: RTL



---
 rtl/bshift_pkg.sv | 13 +
 rtl/bshift_stage.sv | 78 +++++++
 rtl/barrel_shift_pipe.sv | 80 ++++++++
 3 files changed

// File: rtl/bshift_pkg.sv
// Shared constants for the pipelined barrel shifter: shift mode encodings
// and direction encodings used by the top level and each mux stage.
package bshift_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/bshift_stage.sv
// One mux level of the barrel shifter plus its pipeline register.
// Stage K shifts by 2**K when bit K of the carried shift amount is set.
// Build option: BSHIFT_ROTATE_EN adds the wrap-around muxing for rotate mode.
module bshift_stage
  import bshift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH),
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_sel,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  input  logic             in_fill,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_sel,
  output logic             out_dir,
  output logic [1:0]       out_mode,
  output logic             out_fill
);

  localparam int DIST = 1 << K;

  logic             rot;
  logic [WIDTH-1:0] shifted;

  // Shift by this level's fixed distance; fill only applies to non-rotating right shifts.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic left,
                                                   input logic wrap,
                                                   input logic fill);
    logic [WIDTH-1:0] r;
    if (left) begin
      r = d << DIST;
      if (wrap) r = r | (d >> (WIDTH - DIST));
    end else begin
      r = d >> DIST;
      if (wrap) r = r | (d << (WIDTH - DIST));
      else if (fill) r = r | ~({WIDTH{1'b1}} >> DIST);
    end
    return r;
  endfunction

`ifdef BSHIFT_ROTATE_EN
  assign rot = (in_mode == MODE_ROT);
`else
  assign rot = 1'b0;
`endif

  assign shifted = in_sel[K] ? shift_level(in_data, in_dir == DIR_LEFT, rot, in_fill)
                             : in_data;

  // Stage register: advances with the whole pipe, holds everything (bubbles too) on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_sel  <= '0;
      out_dir  <= 1'b0;
      out_mode <= MODE_LOGIC;
      out_fill <= 1'b0;
    end else if (advance) begin
      out_vld  <= in_vld;
      out_data <= shifted;
      out_sel  <= in_sel;
      out_dir  <= in_dir;
      out_mode <= in_mode;
      out_fill <= in_fill;
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: one registered mux level per shift-amount bit,
// valid/ready handshake on both sides, out_zero flag from the last stage.
// Build option: BSHIFT_ROTATE_EN enables rotate mode (otherwise mode 10 is logical).
module barrel_shift_pipe
  import bshift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   sel,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero
);

  logic advance;
  logic accept;

  // Element 0 is the incoming operand, element k+1 is the register of stage k.
  logic [WIDTH-1:0] data_c [0:SHW];
  logic [SHW-1:0]   sel_c  [0:SHW];
  logic             dir_c  [0:SHW];
  logic [1:0]       mode_c [0:SHW];
  logic             fill_c [0:SHW];
  logic             vld_c  [0:SHW];
  logic             unused_tail;

  // The whole pipe moves as one unit whenever the output slot is empty or being drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Sign fill is captured once at entry so later stages need not look at mode.
  assign vld_c[0]  = accept;
  assign data_c[0] = data;
  assign sel_c[0]  = sel;
  assign dir_c[0]  = dir;
  assign mode_c[0] = mode;
  assign fill_c[0] = (mode == MODE_ARITH) && (dir == DIR_RIGHT) && data[WIDTH-1];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    bshift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .K     (k)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .advance  (advance),
      .in_vld   (vld_c[k]),
      .in_data  (data_c[k]),
      .in_sel   (sel_c[k]),
      .in_dir   (dir_c[k]),
      .in_mode  (mode_c[k]),
      .in_fill  (fill_c[k]),
      .out_vld  (vld_c[k+1]),
      .out_data (data_c[k+1]),
      .out_sel  (sel_c[k+1]),
      .out_dir  (dir_c[k+1]),
      .out_mode (mode_c[k+1]),
      .out_fill (fill_c[k+1])
    );
  end

  // Control fields leaving the last stage have no further consumer.
  assign unused_tail = ^{sel_c[SHW], dir_c[SHW], mode_c[SHW], fill_c[SHW]};

  assign out       = data_c[SHW];
  assign out_valid = vld_c[SHW];
  assign out_zero  = (data_c[SHW] == '0);

endmodule
